counter_reload_ctrl: RTL
========================

Name: counter_reload_ctrl

Overview:
Upstream controller for the 4-bit loadable counter. It buffers reload values from a valid/ready producer in a small FIFO and drives the counter's load/load_data pins. It watches the counter's count output. When count reaches a programmable terminal value, it reloads the next buffered value in place of the increment, producing a chain of variable-length count periods. It flags terminal-count events and buffer starvation.

Parameters:
WIDTH, 4, width of count/reload values (must match counter width)
DEPTH, 2, reload FIFO depth in entries (power of 2, >=2)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-high reset (1 = reset asserted, sampled on clk rising edge)
start  input  1  1-cycle pulse: begin sequencing
stop  input  1  1-cycle pulse: return to IDLE
reload_valid  input  1  producer has a reload value
reload_data  input  WIDTH  reload value
reload_ready  output  1  FIFO can accept (= !full)
terminal  input  WIDTH  terminal count value, quasi-static
count  input  WIDTH  counter's current count output
load  output  1  to counter load pin; counter takes load_data on this clk edge
load_data  output  WIDTH  to counter load_data; = FIFO head, 0 when empty
tc_pulse  output  1  1-cycle pulse: count==terminal while in RUN or STARVED
underrun  output  1  sticky: terminal reached with FIFO empty
busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n=1 at edge): state=IDLE, FIFO empty, underrun=0. Outputs: load=0, load_data=0, tc_pulse=0, busy=0, reload_ready=1.
- Output timing: load, load_data, tc_pulse are combinational from registered state, FIFO, count and terminal. All other state is registered. Zero-cycle decision latency, so the counter loads on the same edge where count==terminal.
- FIFO push: on reload_valid && reload_ready. reload_ready=0 when full, even if a pop occurs the same cycle.
- FIFO pop: only when load=1. Pop requires non-empty. No bypass: a value pushed this cycle is visible at the head next cycle.
- Simultaneous push and pop (not full, not empty): occupancy unchanged, order preserved.
- FSM states:
  - IDLE: load=0, tc_pulse=0.
    - start && !stop -> PRIME; clears underrun.
  - PRIME: if FIFO non-empty, load=1 with head, pop, -> RUN. Else stay.
  - RUN: if count==terminal:
    - tc_pulse=1.
    - FIFO non-empty: load=1, pop, stay RUN.
    - FIFO empty: load=0, set underrun, -> STARVED. The counter increments and wraps freely.
  - STARVED: first cycle FIFO is non-empty: load=1, pop, -> RUN, regardless of count.
    - tc_pulse still fires on count==terminal.
- Stop and start priority:
  - stop in any state -> IDLE next cycle; load forced 0 that cycle.
  - FIFO contents are kept.
  - stop has priority over start.
  - start outside IDLE is ignored.
- Reloading a value equal to terminal causes a match on the very next cycle (period of 1). This is legal and handled identically.
- Mid-operation reset: all of the above reset values apply at the next edge. In-flight FIFO data is discarded.
- No arithmetic on count. Comparison is a full WIDTH-bit equality.
- Implementer note: the counter in this codebase has its own reset pin. The integrating level must reset it together with this block.

Test Plan:
- Reset then idle: hold reset_n=1 for 2 cycles, release -> load=0, busy=0, reload_ready=1, underrun=0. start with FIFO empty -> stays PRIME, busy=1, load=0.
- Prime and run: push 3 then 5, terminal=7, pulse start.
  - PRIME cycle: load=1, load_data=3.
  - Counter counts 3..7. At count=7: tc_pulse=1, load=1, load_data=5.
  - Next cycle count=5.
- Starvation: FIFO empty at count==terminal=7 -> tc_pulse=1, load=0, underrun=1 (sticky), state STARVED.
  - Counter shows 8.
  - Push 2 -> next cycle load=1, load_data=2, back to RUN.
- Backpressure: DEPTH=2; push 1,2 while IDLE -> reload_ready=0; third valid held, not accepted. After one pop, ready=1 next cycle; FIFO order 2, then the held value.
- Stop priority: in RUN, assert start and stop in the same cycle as count==terminal -> load=0 that cycle, IDLE next cycle, FIFO occupancy unchanged.
- Period-1 reload: terminal=4, push 4,4,9 -> tc_pulse on consecutive cycles for both 4s, then load_data=9.

Source files
------------

// File: rtl/counter_reload_ctrl.sv
// ---------------------------------------------------------------------------
// counter_reload_ctrl
//
// Upstream controller for a loadable counter. Reload values arrive over a
// valid/ready handshake and are buffered in a small FIFO. While running, the
// block watches the counter's count. When count equals the terminal value,
// the block loads the next buffered value in place of the increment. This
// chains count periods of variable length. The block also reports
// terminal-count events and buffer starvation.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous reset, ACTIVE HIGH (1 = reset)
//   start         1-cycle pulse, leave IDLE and begin sequencing
//   stop          1-cycle pulse, return to IDLE (wins over start)
//   reload_valid  producer offers reload_data
//   reload_data   reload value
//   reload_ready  FIFO not full
//   terminal      terminal count value (quasi-static)
//   count         counter's current count
//   load          counter load strobe (taken on this clk edge)
//   load_data     FIFO head, zero when the FIFO is empty
//   tc_pulse      count == terminal while in RUN or STARVED
//   underrun      sticky, terminal reached with an empty FIFO
//   busy          state != IDLE
// ---------------------------------------------------------------------------
module counter_reload_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             reload_valid,
    input  logic [WIDTH-1:0] reload_data,
    output logic             reload_ready,
    input  logic [WIDTH-1:0] terminal,
    input  logic [WIDTH-1:0] count,
    output logic             load,
    output logic [WIDTH-1:0] load_data,
    output logic             tc_pulse,
    output logic             underrun,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_OCC = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRIME   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_STARVED = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             underrun_q, underrun_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      occ_q, occ_d;

    logic empty_s;
    logic full_s;
    logic push_s;
    logic pop_s;
    logic match_s;
    logic load_s;
    logic tc_s;

    assign empty_s = (occ_q == {(AW + 1){1'b0}});
    assign full_s  = (occ_q == FULL_OCC);
    // Ready depends only on the stored occupancy. A pop in the same cycle
    // does not free a slot for this cycle's push.
    assign push_s  = reload_valid && !full_s;
    // load is only raised with a non-empty FIFO, so every load is a pop.
    assign pop_s   = load_s;
    assign match_s = (count == terminal);

    assign reload_ready = !full_s;
    assign load         = load_s;
    assign load_data    = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign tc_pulse     = tc_s;
    assign underrun     = underrun_q;
    assign busy         = (state_q != ST_IDLE);

    // Sequencing decisions: next state, load strobe, terminal pulse, underrun flag
    always_comb begin
        state_d    = state_q;
        underrun_d = underrun_q;
        load_s     = 1'b0;
        tc_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_PRIME;
                    underrun_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!empty_s) begin
                    load_s  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_RUN: begin
                tc_s = match_s;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (match_s && !empty_s) begin
                    load_s  = 1'b1;
                    state_d = ST_RUN;
                end else if (match_s) begin
                    // Nothing buffered: let the counter run on and flag it.
                    underrun_d = 1'b1;
                    state_d    = ST_STARVED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STARVED: begin
                tc_s = match_s;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!empty_s) begin
                    // Resynchronise as soon as data shows up, whatever the count.
                    load_s  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STARVED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            occ_q      <= {(AW + 1){1'b0}};
        end else begin
            state_q    <= state_d;
            underrun_q <= underrun_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // FIFO storage. Entries are only read when occupancy covers them, so the
    // storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= reload_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule
